// File: rtl/commutation_controller.sv
// BLDC 6-step commutation: hall sync/filter, dead time, direction, faults.
// In: clock reset hall enable direction duty_cycle fault_clear; Out: phase_duty phase_z hall_count fault state.
module commutation_controller #(
  parameter int DUTY_WIDTH    = 8,
  parameter int FILTER_CYCLES = 4,
  parameter int DEAD_CYCLES   = 16,
  parameter int STALL_CYCLES  = 1000000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [2:0]              hall,
  input  logic                    enable,
  input  logic                    direction,
  input  logic [DUTY_WIDTH-1:0]   duty_cycle,
  input  logic                    fault_clear,
  output logic [3*DUTY_WIDTH-1:0] phase_duty,
  output logic [2:0]              phase_z,
  output logic [15:0]             hall_count,
  output logic [1:0]              fault,
  output logic [1:0]              state
);
  localparam int W  = DUTY_WIDTH;
  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam int DW = $clog2(DEAD_CYCLES + 1);
  localparam int SW = $clog2(STALL_CYCLES + 1);
  localparam logic [FW-1:0] F_MAX  = FW'(FILTER_CYCLES);
  localparam logic [DW-1:0] D_LAST = DW'(DEAD_CYCLES - 1);
  localparam logic [SW-1:0] S_MAX  = SW'(STALL_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DEAD  = 2'd1,
    DRIVE = 2'd2,
    FAULT = 2'd3
  } state_e;

  logic [2:0]    h1_q, h2_q, cand_q;
  logic [2:0]    hall_f_q, hall_f_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          hall_chg, hall_vld_q;
  state_e        st_q, st_d;
  logic [DW-1:0] dead_q, dead_d;
  logic [SW-1:0] stall_q, stall_d;
  logic          dir_q, dir_chg;
  logic [1:0]    fault_q, fault_d, fault_set;
  logic [15:0]   cnt_q, cnt_d;
  logic [2:0]    pos_o, pos_n;
  logic [3*W-1:0] pd_q, pd_d;
  logic [2:0]    pz_q, pz_d;
  logic [2:0]    hi, lo;

  // Position in the forward sequence 001,011,010,110,100,101; 7 = invalid.
  function automatic logic [2:0] seq_pos(input logic [2:0] h);
    case (h)
      3'b001:  return 3'd0;
      3'b011:  return 3'd1;
      3'b010:  return 3'd2;
      3'b110:  return 3'd3;
      3'b100:  return 3'd4;
      3'b101:  return 3'd5;
      default: return 3'd7;
    endcase
  endfunction

  function automatic logic [2:0] seq_next(input logic [2:0] p);
    return (p == 3'd5) ? 3'd0 : p + 3'd1;
  endfunction

  // Filter: count consecutive identical synced samples.
  always_comb begin
    fcnt_d = (h2_q == cand_q) ? fcnt_q : '0;
    if (fcnt_d != F_MAX) fcnt_d = fcnt_d + 1'b1;
    hall_f_d = (fcnt_d == F_MAX) ? h2_q : hall_f_q;
    hall_chg = (hall_f_d != hall_f_q);
  end

  always_comb begin
    pos_o = seq_pos(hall_f_q);
    pos_n = seq_pos(hall_f_d);
    cnt_d = cnt_q;
    if (hall_chg && pos_o != 3'd7 && pos_n != 3'd7) begin
      if (pos_n == seq_next(pos_o))      cnt_d = cnt_q + 16'd1;
      else if (pos_o == seq_next(pos_n)) cnt_d = cnt_q - 16'd1;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (st_q != DRIVE || duty_cycle == '0 || hall_chg) stall_d = '0;
    else if (stall_q != S_MAX) stall_d = stall_q + 1'b1;
  end

  assign dir_chg = (direction != dir_q);

  // hall_vld_q masks the reset value 000 until a real code is filtered in.
  always_comb begin
    fault_set[0] = hall_vld_q && enable &&
                   (hall_f_q == 3'b000 || hall_f_q == 3'b111);
    fault_set[1] = (stall_d == S_MAX);
    fault_d = (st_q == FAULT && fault_clear) ? fault_set
                                              : (fault_q | fault_set);
    st_d   = st_q;
    dead_d = dead_q;
    if (|fault_set) begin
      st_d = FAULT;
    end else if (st_q == FAULT) begin
      if (fault_clear) st_d = IDLE;
    end else if (!enable) begin
      st_d = IDLE;
    end else begin
      unique case (st_q)
        IDLE: begin
          st_d   = DEAD;
          dead_d = '0;
        end
        DEAD: begin
          if (hall_chg)              dead_d = '0;
          else if (dead_q == D_LAST) st_d = DRIVE;
          else                       dead_d = dead_q + 1'b1;
        end
        DRIVE: begin
          if (hall_chg || dir_chg) begin
            st_d   = DEAD;
            dead_d = '0;
          end
        end
        default: st_d = IDLE;
      endcase
    end
  end

  // Table uses dir_q so a direction flip never reverses drive without dead time.
  always_comb begin
    hi = 3'b000;
    lo = 3'b000;
    case (hall_f_q)
      3'b101:  begin hi = 3'b100; lo = 3'b010; end
      3'b100:  begin hi = 3'b100; lo = 3'b001; end
      3'b110:  begin hi = 3'b010; lo = 3'b001; end
      3'b010:  begin hi = 3'b010; lo = 3'b100; end
      3'b011:  begin hi = 3'b001; lo = 3'b100; end
      3'b001:  begin hi = 3'b001; lo = 3'b010; end
      default: begin hi = 3'b000; lo = 3'b000; end
    endcase
    if (dir_q) {hi, lo} = {lo, hi};
    pd_d = '0;
    pz_d = 3'b111;
    if (st_q == DRIVE) begin
      for (int i = 0; i < 3; i++) begin
        if (hi[i]) pd_d[i*W +: W] = duty_cycle;
        pz_d[i] = ~(hi[i] | lo[i]);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h1_q       <= '0;
      h2_q       <= '0;
      cand_q     <= '0;
      fcnt_q     <= '0;
      hall_f_q   <= '0;
      hall_vld_q <= 1'b0;
      st_q       <= IDLE;
      dead_q     <= '0;
      stall_q    <= '0;
      dir_q      <= 1'b0;
      fault_q    <= '0;
      cnt_q      <= '0;
      pd_q       <= '0;
      pz_q       <= 3'b111;
    end else begin
      h1_q     <= hall;
      h2_q     <= h1_q;
      cand_q   <= h2_q;
      fcnt_q   <= fcnt_d;
      hall_f_q <= hall_f_d;
      if (hall_chg) hall_vld_q <= 1'b1;
      st_q     <= st_d;
      dead_q   <= dead_d;
      stall_q  <= stall_d;
      dir_q    <= direction;
      fault_q  <= fault_d;
      cnt_q    <= cnt_d;
      pd_q     <= pd_d;
      pz_q     <= pz_d;
    end
  end

  assign phase_duty = pd_q;
  assign phase_z    = pz_q;
  assign hall_count = cnt_q;
  assign fault      = fault_q;
  assign state      = st_q;

endmodule

// File: tb/tb_commutation_controller.sv
// Scoreboard bench for commutation_controller.
// Two instances: default parameters, and STALL_CYCLES=50 for the stall scenario.
module tb_commutation_controller;
  localparam int W = 8;
  localparam int DEAD = 16;

  logic         clock = 1'b0;
  logic         reset, enable, direction, fault_clear;
  logic [2:0]   hall;
  logic [W-1:0] duty;
  logic [3*W-1:0] pd, pd2;
  logic [2:0]   pz, pz2;
  logic [15:0]  cnt, cnt2;
  logic [1:0]   flt, flt2, st, st2;

  always #5 clock = ~clock;

  commutation_controller dut (
    .clock(clock), .reset(reset), .hall(hall),
    .enable(enable), .direction(direction),
    .duty_cycle(duty), .fault_clear(fault_clear),
    .phase_duty(pd), .phase_z(pz), .hall_count(cnt),
    .fault(flt), .state(st)
  );

  commutation_controller #(.STALL_CYCLES(50)) dut2 (
    .clock(clock), .reset(reset), .hall(hall),
    .enable(enable), .direction(direction),
    .duty_cycle(duty), .fault_clear(fault_clear),
    .phase_duty(pd2), .phase_z(pz2), .hall_count(cnt2),
    .fault(flt2), .state(st2)
  );

  typedef struct {
    logic [3*W-1:0] pd;
    logic [2:0]     pz;
    logic [15:0]    cnt;
  } exp_t;

  exp_t sbq[$];
  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] m_cnt;
  logic [2:0]  m_hall;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int seq_pos(input logic [2:0] h);
    case (h)
      3'b001: return 0;
      3'b011: return 1;
      3'b010: return 2;
      3'b110: return 3;
      3'b100: return 4;
      3'b101: return 5;
      default: return -1;
    endcase
  endfunction

  // Bit positions: A=2, B=1, C=0.
  function automatic exp_t expect_for(input logic [2:0] h,
    input logic d, input logic [W-1:0] dc, input logic [15:0] c);
    int hi, lo, t;
    exp_t e;
    case (h)
      3'b101: begin hi = 2; lo = 1; end
      3'b100: begin hi = 2; lo = 0; end
      3'b110: begin hi = 1; lo = 0; end
      3'b010: begin hi = 1; lo = 2; end
      3'b011: begin hi = 0; lo = 2; end
      3'b001: begin hi = 0; lo = 1; end
      default: begin hi = -1; lo = -1; end
    endcase
    if (d) begin t = hi; hi = lo; lo = t; end
    e.pd = '0;
    e.pz = 3'b111;
    if (hi >= 0) begin
      e.pd[hi*W +: W] = dc;
      e.pz[hi] = 1'b0;
      e.pz[lo] = 1'b0;
    end
    e.cnt = c;
    return e;
  endfunction

  task automatic set_hall(input logic [2:0] h);
    int pn, po;
    pn = seq_pos(h);
    po = seq_pos(m_hall);
    if (pn >= 0 && po >= 0) begin
      if (pn == (po + 1) % 6)      m_cnt = m_cnt + 16'd1;
      else if (pn == (po + 5) % 6) m_cnt = m_cnt - 16'd1;
    end
    m_hall = h;
    hall = h;
  endtask

  task automatic push_exp();
    sbq.push_back(expect_for(m_hall, direction, duty, m_cnt));
  endtask

  // Waits for a float gap followed by driven outputs, then checks the head.
  task automatic await_drive(input string tag, input int want_gap);
    int floats;
    bit seen;
    exp_t e;
    floats = 0;
    seen = 0;
    for (int c = 0; c < 400 && !seen; c++) begin
      tick();
      if (pz == 3'b111) floats++;
      else if (floats > 0) seen = 1;
    end
    e = sbq.pop_front();
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s_timeout: floats=%0d no drive", tag, floats);
    end else begin
      n_cmp++;
      if (pd !== e.pd) begin
        n_err++;
        $display("FAIL %s_duty: got %h want %h", tag, pd, e.pd);
      end
      n_cmp++;
      if (pz !== e.pz) begin
        n_err++;
        $display("FAIL %s_z: got %b want %b", tag, pz, e.pz);
      end
      n_cmp++;
      if (cnt !== e.cnt) begin
        n_err++;
        $display("FAIL %s_count: got %0d want %0d", tag, cnt, e.cnt);
      end
      n_cmp++;
      if (floats != want_gap) begin
        n_err++;
        $display("FAIL %s_gap: got %0d want %0d", tag, floats, want_gap);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b0;
    direction = 1'b0;
    fault_clear = 1'b0;
    duty = 8'h80;
    m_hall = 3'b000;
    m_cnt = 16'd0;
    set_hall(3'b101);
    tick();
    tick();
    n_cmp++;
    if (st !== 2'd0) begin
      n_err++;
      $display("FAIL rst_state: got %0d want 0", st);
    end
    n_cmp++;
    if (pz !== 3'b111) begin
      n_err++;
      $display("FAIL rst_z: got %b want 111", pz);
    end
    n_cmp++;
    if (pd !== '0) begin
      n_err++;
      $display("FAIL rst_duty: got %h want 0", pd);
    end
    n_cmp++;
    if (cnt !== 16'd0) begin
      n_err++;
      $display("FAIL rst_count: got %0d want 0", cnt);
    end
    n_cmp++;
    if (flt !== 2'b00) begin
      n_err++;
      $display("FAIL rst_fault: got %b want 00", flt);
    end
    reset = 1'b0;
    repeat (10) tick();
    n_cmp++;
    if (st !== 2'd0 || flt !== 2'b00) begin
      n_err++;
      $display("FAIL idle_hold: got st=%0d f=%b want 0/00", st, flt);
    end
  endtask

  // From IDLE: one clock to enter DEAD plus the DEAD period, all floating.
  task automatic test_startup();
    enable = 1'b1;
    push_exp();
    await_drive("startup", DEAD + 1);
  endtask

  task automatic test_sequence(input bit rev);
    logic [2:0] fw [6];
    logic [2:0] rv [6];
    fw = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};
    rv = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
    for (int i = 0; i < 6; i++) begin
      set_hall(rev ? rv[i] : fw[i]);
      push_exp();
      await_drive(rev ? "rev_step" : "fwd_step", DEAD);
      repeat (170) tick();
    end
    n_cmp++;
    if (cnt !== (rev ? 16'd0 : 16'd6)) begin
      n_err++;
      $display("FAIL seq_total: got %0d want %0d", cnt, rev ? 0 : 6);
    end
  endtask

  task automatic test_direction();
    set_hall(3'b100);
    push_exp();
    await_drive("dir_pre", DEAD);
    direction = 1'b1;
    push_exp();
    await_drive("dir_rev", DEAD);
    direction = 1'b0;
    push_exp();
    await_drive("dir_fwd", DEAD);
    set_hall(3'b101);
    push_exp();
    await_drive("dir_back", DEAD);
  endtask

  task automatic test_glitch();
    exp_t e;
    bit bad;
    e = expect_for(3'b101, 1'b0, duty, m_cnt);
    bad = 0;
    hall = 3'b100;
    repeat (3) tick();
    hall = 3'b101;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (pz !== e.pz || pd !== e.pd || st !== 2'd2) bad = 1;
    end
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("FAIL glitch_hold: got pz=%b st=%0d want %b/2", pz, st, e.pz);
    end
    n_cmp++;
    if (cnt !== m_cnt) begin
      n_err++;
      $display("FAIL glitch_count: got %0d want %0d", cnt, m_cnt);
    end
    duty = 8'h40;
    tick();
    tick();
    e = expect_for(3'b101, 1'b0, 8'h40, m_cnt);
    n_cmp++;
    if (pd !== e.pd || pz !== e.pz) begin
      n_err++;
      $display("FAIL duty_track: got %h/%b want %h/%b", pd, pz, e.pd, e.pz);
    end
    duty = 8'h80;
    tick();
  endtask

  task automatic test_fault();
    bit hit;
    hit = 0;
    set_hall(3'b111);
    for (int i = 0; i < 20 && !hit; i++) begin
      tick();
      if (st == 2'd3) hit = 1;
    end
    n_cmp++;
    if (!hit) begin
      n_err++;
      $display("FAIL inv_enter: got st=%0d want 3", st);
    end
    tick();
    n_cmp++;
    if (flt !== 2'b01 || pz !== 3'b111 || pd !== '0) begin
      n_err++;
      $display("FAIL inv_out: got f=%b z=%b d=%h want 01/111/0", flt, pz, pd);
    end
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    n_cmp++;
    if (st !== 2'd3 || flt !== 2'b01) begin
      n_err++;
      $display("FAIL clr_blocked: got st=%0d f=%b want 3/01", st, flt);
    end
    set_hall(3'b101);
    repeat (12) tick();
    n_cmp++;
    if (st !== 2'd3 || flt !== 2'b01) begin
      n_err++;
      $display("FAIL sticky: got st=%0d f=%b want 3/01", st, flt);
    end
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    n_cmp++;
    if (st !== 2'd0 || flt !== 2'b00) begin
      n_err++;
      $display("FAIL clr_ok: got st=%0d f=%b want 0/00", st, flt);
    end
    push_exp();
    await_drive("restart", DEAD + 1);
  endtask

  task automatic test_stall();
    int drv;
    bit hit;
    for (int run = 0; run < 2; run++) begin
      reset = 1'b1;
      enable = 1'b0;
      duty = (run == 0) ? 8'd1 : 8'd0;
      tick();
      reset = 1'b0;
      repeat (10) tick();
      n_cmp++;
      if (cnt2 !== 16'd0 || flt2 !== 2'b00) begin
        n_err++;
        $display("FAIL stall_rst: got c=%0d f=%b want 0/00", cnt2, flt2);
      end
      enable = 1'b1;
      drv = 0;
      hit = 0;
      for (int i = 0; i < 300 && !hit; i++) begin
        tick();
        if (st2 == 2'd2) drv++;
        else if (st2 == 2'd3) hit = 1;
      end
      if (run == 0) begin
        n_cmp++;
        if (!hit || drv != 50) begin
          n_err++;
          $display("FAIL stall_at: got drive=%0d hit=%0d want 50/1", drv, hit);
        end
        tick();
        n_cmp++;
        if (flt2 !== 2'b10 || pz2 !== 3'b111) begin
          n_err++;
          $display("FAIL stall_out: got f=%b z=%b want 10/111", flt2, pz2);
        end
      end else begin
        n_cmp++;
        if (hit || st2 !== 2'd2 || flt2 !== 2'b00) begin
          n_err++;
          $display("FAIL stall_zero: got st=%0d f=%b want 2/00", st2, flt2);
        end
        n_cmp++;
        if (pz2 !== 3'b001 || pd2 !== '0) begin
          n_err++;
          $display("FAIL zero_out: got z=%b d=%h want 001/0", pz2, pd2);
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_startup();
    test_sequence(1'b0);
    test_sequence(1'b1);
    test_direction();
    test_glitch();
    test_fault();
    test_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
